// File: rtl/timer_counter.sv
// Memory-mapped down-counter timer: CTRL/PRESET/COUNT registers in a 16-byte window,
// with one-shot or auto-reload expiry and a maskable level interrupt.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    state_t      state, state_next;
    logic [3:0]  ctrl, ctrl_next;
    logic [31:0] preset, preset_next;
    logic [31:0] count, count_next;
    logic        pending, pending_next;

    logic        win, wr, ctrl_wr, preset_wr;
    logic        en, auto_reload, set_pending, en_clear;
    logic [1:0]  offset;
    logic        unused_addr_bits;

    assign win         = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = addr[3:2];
    assign wr          = win && (|byteen);
    assign ctrl_wr     = wr && (offset == OFF_CTRL);
    assign preset_wr   = wr && (offset == OFF_PRESET);
    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign unused_addr_bits = ^addr[1:0];

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next  = state;
        count_next  = count;
        set_pending = 1'b0;
        en_clear    = 1'b0;
        case (state)
            IDLE: if (en) state_next = LOAD;
            LOAD: begin
                count_next = preset;
                state_next = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // PRESET of 0 or 1 both expire here, so COUNT never wraps below zero
                    count_next  = '0;
                    set_pending = 1'b1;
                    state_next  = INT;
                end
            end
            INT: begin
                state_next = IDLE;
                en_clear   = !auto_reload;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ctrl_next   = ctrl;
        preset_next = preset;
        if (en_clear) ctrl_next[0] = 1'b0;
        // A bus write to CTRL is applied after the one-shot EN clear so it takes priority
        if (ctrl_wr && byteen[0]) ctrl_next = wdata[3:0];
        if (preset_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteen[i]) preset_next[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        pending_next = pending;
        if (set_pending)
            pending_next = 1'b1;
        else if (pending && (auto_reload || ctrl_wr || preset_wr))
            pending_next = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ctrl    <= '0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_next;
            ctrl    <= ctrl_next;
            preset  <= preset_next;
            count   <= count_next;
            pending <= pending_next;
        end
    end

    always_comb begin
        rdata = '0;
        if (win) begin
            case (offset)
                OFF_CTRL:   rdata = {28'd0, ctrl};
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = pending && ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: register vector table, timed scenarios,
// and randomized bus traffic checked against a spec-level reference model.
module tb_timer_counter;

    localparam logic [31:0] BASE   = 32'h0000_7f00;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'h4;
    localparam logic [31:0] A_CNT  = BASE + 32'h8;
    localparam logic [31:0] A_UNM  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [31:0] waddr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    // Reference model state: the four spec phases, tracked as plain integers
    int          m_phase;  // 0 idle, 1 load, 2 counting, 3 expired
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    bit          m_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        @(posedge clk); #1;
        byteen = '0; wdata = '0;
    endtask

    task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
        addr = a; byteen = '0;
        #1;
        d = rdata;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
        m_phase = 0; m_ctrl = '0; m_preset = '0; m_count = '0; m_pend = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return '0;
        case (a[3:2])
            2'd0: return {28'd0, m_ctrl};
            2'd1: return m_preset;
            2'd2: return m_count;
            default: return '0;
        endcase
    endfunction

    task automatic model_step(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bit          in_win = (a[31:4] == BASE[31:4]);
        bit          ctrl_w = in_win && (be != 0) && (a[3:2] == 2'd0);
        bit          pre_w  = in_win && (be != 0) && (a[3:2] == 2'd1);
        bit          reload = (m_ctrl[2:1] == 2'b01);
        bit          fired  = 0;
        int          ph     = m_phase;
        logic [3:0]  c      = m_ctrl;
        logic [31:0] p      = m_preset;
        logic [31:0] n      = m_count;
        if (m_phase == 0 && m_ctrl[0]) ph = 1;
        if (m_phase == 1) begin n = m_preset; ph = 2; end
        if (m_phase == 2) begin
            if (!m_ctrl[0]) ph = 0;
            else if (m_count > 1) n = m_count - 1;
            else begin n = 0; fired = 1; ph = 3; end
        end
        if (m_phase == 3) begin
            ph = 0;
            if (!reload) c[0] = 1'b0;
        end
        if (ctrl_w && be[0]) c = d[3:0];
        for (int i = 0; i < 4; i++) if (pre_w && be[i]) p[8*i +: 8] = d[8*i +: 8];
        if (fired) m_pend = 1;
        else if (reload || ctrl_w || pre_w) m_pend = 0;
        m_phase = ph; m_ctrl = c; m_preset = p; m_count = n;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] ra, rd;
        logic [3:0]  rb;
        int          r;

        vecs[0]  = '{A_PRE,  4'b0010, 32'hAABBCCDD, A_PRE,          32'h0000CC00};
        vecs[1]  = '{A_CNT,  4'b1111, 32'hFFFFFFFF, A_CNT,          32'h0};
        vecs[2]  = '{BASE + 32'd16, 4'b1111, 32'h12345678, A_PRE,   32'h0000CC00};
        vecs[3]  = '{A_UNM,  4'b1111, 32'hFFFFFFFF, A_CTRL,         32'h0};
        vecs[4]  = '{A_CTRL, 4'b1111, 32'hFFFFFFF6, A_CTRL,         32'h6};
        vecs[5]  = '{A_PRE,  4'b1111, 32'h12345678, A_PRE,          32'h12345678};
        vecs[6]  = '{A_PRE,  4'b1000, 32'h9A000000, A_PRE | 32'h3,  32'h9A345678};
        vecs[7]  = '{A_UNM,  4'b1111, 32'hFFFFFFFF, A_UNM,          32'h0};
        vecs[8]  = '{A_CTRL, 4'b0000, 32'h0000000F, A_CTRL,         32'h6};
        vecs[9]  = '{A_CTRL, 4'b1110, 32'hFFFFFFFF, A_CTRL,         32'h6};
        vecs[10] = '{BASE + 32'h100, 4'b1111, 32'h0, BASE + 32'h108, 32'h0};

        // Reset state
        #5;
        do_reset();
        step(1);
        read_reg(A_CTRL, v); check("reset_ctrl", v, 32'h0);
        read_reg(A_PRE, v);  check("reset_preset", v, 32'h0);
        read_reg(A_CNT, v);  check("reset_count", v, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);

        // Register access table (timer disabled throughout)
        foreach (vecs[i]) begin
            bus_write(vecs[i].waddr, vecs[i].be, vecs[i].wd);
            read_reg(vecs[i].raddr, v);
            check($sformatf("vec%0d", i), v, vecs[i].exp);
        end

        // One-shot expiry with interrupt, held until a CTRL write
        do_reset();
        bus_write(A_PRE, 4'hF, 32'd5);
        bus_write(A_CTRL, 4'hF, 32'h9);
        step(2); read_reg(A_CNT, v); check("os_count_load", v, 32'd5);
        step(4); read_reg(A_CNT, v); check("os_count_one", v, 32'd1);
        check("os_irq_before", {31'd0, irq}, 32'd0);
        step(1); read_reg(A_CNT, v); check("os_count_zero", v, 32'd0);
        check("os_irq_set", {31'd0, irq}, 32'd1);
        step(1); read_reg(A_CTRL, v); check("os_en_cleared", v, 32'h8);
        step(3); check("os_irq_held", {31'd0, irq}, 32'd1);
        read_reg(A_CNT, v); check("os_count_stays", v, 32'd0);
        bus_write(A_CTRL, 4'hF, 32'h8);
        check("os_irq_cleared", {31'd0, irq}, 32'd0);

        // Auto-reload: one-cycle pulse every 6 edges, COUNT 3,2,1,0 repeating
        do_reset();
        bus_write(A_PRE, 4'hF, 32'd3);
        bus_write(A_CTRL, 4'hF, 32'hB);
        addr = A_CNT;
        for (int k = 1; k <= 20; k++) begin
            int ph;
            logic [31:0] exp_cnt;
            step(1);
            ph = (k - 2) % 6;
            exp_cnt = (k < 2 || ph >= 3) ? 32'd0 : 32'(3 - ph);
            check($sformatf("ar_irq_e%0d", k), {31'd0, irq},
                  (k >= 5 && (k - 5) % 6 == 0) ? 32'd1 : 32'd0);
            check($sformatf("ar_count_e%0d", k), rdata, exp_cnt);
        end

        // Masked expiry: pending set but irq low; CTRL write with IM=1 clears pending
        do_reset();
        bus_write(A_PRE, 4'hF, 32'd2);
        bus_write(A_CTRL, 4'hF, 32'h1);
        step(6);
        check("mask_irq_low", {31'd0, irq}, 32'd0);
        read_reg(A_CTRL, v); check("mask_en_cleared", v, 32'h0);
        bus_write(A_CTRL, 4'hF, 32'h8);
        check("mask_write_clears", {31'd0, irq}, 32'd0);

        // Early stop: clearing EN mid-count freezes COUNT
        do_reset();
        bus_write(A_PRE, 4'hF, 32'd10);
        bus_write(A_CTRL, 4'hF, 32'h1);
        step(5);
        bus_write(A_CTRL, 4'hF, 32'h0);
        step(4);
        read_reg(A_CNT, v); check("stop_count_frozen", v, 32'd6);

        // Asynchronous reset mid-count
        do_reset();
        bus_write(A_PRE, 4'hF, 32'd20);
        bus_write(A_CTRL, 4'hF, 32'h9);
        step(15);
        read_reg(A_CNT, v); check("midrst_count_before", v, 32'd7);
        reset = 1'b0;
        #1;
        read_reg(A_CNT, v);  check("midrst_count", v, 32'd0);
        read_reg(A_CTRL, v); check("midrst_ctrl", v, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Randomized bus traffic against the reference model
        do_reset();
        step(1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = $urandom_range(0, 99);
            if (r < 85)      ra = BASE | 32'($urandom_range(0, 15));
            else if (r < 93) ra = BASE + 32'd16 + 32'($urandom_range(0, 15));
            else             ra = $urandom;
            rb = ($urandom_range(0, 99) < 30) ? 4'($urandom_range(1, 15)) : 4'd0;
            if (ra[3:2] == 2'd1) begin
                rd = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 5));
            end else begin
                rd = $urandom;
                if (ra[3:2] == 2'd0) rd[0] = ($urandom_range(0, 3) != 0);
            end
            addr = ra; byteen = rb; wdata = rd;
            #1;
            check($sformatf("rnd_rdata_c%0d", cyc), rdata, model_read(ra));
            check($sformatf("rnd_irq_c%0d", cyc), {31'd0, irq},
                  {31'd0, m_pend && m_ctrl[3]});
            @(posedge clk);
            model_step(ra, rb, rd);
            #1;
        end
        byteen = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_7f00, meaning the 16-byte-aligned base of the register window.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port addr, input, 32, the bus byte address from the CPU memory stage.
REQ-005 SHALL have port byteen, input, 4, per-byte write enable; bit i covers wdata[8i+7:8i]; all-zero means no write.
REQ-006 SHALL have port wdata, input, 32, bus write data.
REQ-007 SHALL have port rdata, output, 32, combinational read data of the addressed register.
REQ-008 SHALL have port irq, output, 1, level interrupt request to the CPU.

Function
REQ-009 Register map, decoded only when addr[31:4]==BASE_ADDR[31:4]: +0x0 CTRL, +0x4 PRESET, +0x8 COUNT (read-only), +0xC unmapped.
REQ-010 CTRL SHALL hold: [0] EN (enable), [2:1] MODE (00 one-shot, 01 auto-reload; 10/11 behave as 00), [3] IM (interrupt mask); bits [31:4] read 0 and ignore writes.
REQ-011 Write SHALL occur at the clock edge when |byteen and the window matches; only enabled bytes change; writes to COUNT, +0xC or outside the window are ignored.
REQ-012 rdata SHALL be the addressed register (addr[1:0] ignored); 0 for +0xC or outside the window.
REQ-013 FSM states IDLE, LOAD, CNT, INT; COUNT changes only per REQ-014 to REQ-017.
REQ-014 IDLE: EN=1 -> LOAD; else stay.
REQ-015 LOAD: COUNT <= PRESET; -> CNT.
REQ-016 CNT: EN=0 -> IDLE, COUNT holds; else if COUNT>1, COUNT <= COUNT-1; else COUNT <= 0, pending <= 1, -> INT.
REQ-017 INT: -> IDLE; MODE 00 SHALL clear EN in the same edge; MODE 01 leaves EN set, so the count reloads.
REQ-018 Latency: with EN set at edge 0 in IDLE, INT SHALL be entered at edge 2+max(PRESET,1); PRESET=0 is treated as 1.
REQ-019 irq SHALL equal pending AND IM.
REQ-020 pending behaviour by MODE:
- MODE 00: held until any window write to CTRL or PRESET.
- MODE 01: cleared on the next edge, giving a one-cycle pulse.
REQ-021 Priority in the same edge:
- A bus write to CTRL wins over the INT-state EN clear.
- pending set wins over a clearing write.
REQ-022 A PRESET write while in CNT SHALL NOT affect COUNT until the next LOAD.
REQ-023 COUNT arithmetic SHALL be 32-bit unsigned and never decrement below 0.

Reset
REQ-024 reset low SHALL immediately force: CTRL=0, PRESET=0, COUNT=0, state IDLE, pending=0, irq=0.
REQ-025 rdata SHALL then read 0 for all registers, including when reset is asserted mid-count; operation resumes only via new writes after release.

Verification
REQ-026 After reset release, read CTRL, PRESET and COUNT -> all 0; irq=0.
REQ-027 Write PRESET=5, then CTRL=0x9 (EN, MODE 00, IM) at edge 0:
- COUNT=5 after edge 2, reaches 1 after edge 6, becomes 0 after edge 7.
- irq=1 from edge 7 and stays high.
- CTRL.EN reads 0.
- A subsequent CTRL write clears irq.
REQ-028 PRESET=3, CTRL=0xB (auto-reload, IM) -> irq pulses exactly one cycle every 6 edges; COUNT sequence is 3,2,1,0 repeating.
REQ-029 Byteen checks:
- Write PRESET with byteen=4'b0010, wdata=32'hAABBCCDD over PRESET=0 -> PRESET=32'h0000CC00.
- Write COUNT -> COUNT unchanged.
- Write with addr=BASE_ADDR+16 -> no register changes.
REQ-030 Mask and early stop:
- IM=0 with MODE 00 expiry -> irq=0 while pending=1; a later write of CTRL=0x8 -> irq stays 0, because the write clears pending.
- Clearing EN mid-CNT -> COUNT freezes.
REQ-031 Assert reset low mid-CNT with COUNT=7 -> COUNT, CTRL and irq read 0 before the next clock edge.
